// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core: stage enables, IF/ID flush, ID/EX bubble,
// load-use stall detection, run/single-step control and HALT drain, plus cycle/stall counters.
module pipeline_hazard_ctrl #(
   parameter int unsigned CNT_W     = 32,
   parameter int unsigned DRAIN_CYC = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_run_mode,
   input  logic             i_step,
   input  logic             i_id_valid,
   input  logic             i_id_halt,
   input  logic [4:0]       i_id_rs,
   input  logic [4:0]       i_id_rt,
   input  logic             i_id_uses_rt,
   input  logic             i_id_pc_modify,
   input  logic             i_ex_mem_read,
   input  logic [4:0]       i_ex_rt,
   output logic             o_pc_en,
   output logic             o_if_id_en,
   output logic             o_if_id_flush,
   output logic             o_id_ex_bubble,
   output logic             o_pipe_en,
   output logic             o_halted,
   output logic [CNT_W-1:0] o_cycle_cnt,
   output logic [CNT_W-1:0] o_stall_cnt
);

   localparam int unsigned DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYC - 1);

   typedef enum logic [2:0] {StIdle, StRun, StStep, StDrain, StHalted} state_e;

   state_e           state_q, state_d;
   logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
   logic             halted_q;
   logic [CNT_W-1:0] cycle_cnt_q, stall_cnt_q;

   logic adv, hazard, halt_go, rs_match, rt_match;

   assign adv      = (state_q == StRun) || (state_q == StStep);
   // r0 is hardwired zero, so a load targeting it never creates a dependency
   assign rs_match = (i_ex_rt == i_id_rs);
   assign rt_match = i_id_uses_rt && (i_ex_rt == i_id_rt);
   assign hazard   = i_ex_mem_read && (i_ex_rt != 5'd0) && (rs_match || rt_match) && i_id_valid;
   assign halt_go  = adv && i_id_valid && i_id_halt && !hazard;

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= StIdle;
         drain_cnt_q <= '0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         halted_q    <= (state_d == StHalted);
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      drain_cnt_d = '0;
      unique case (state_q)
         StIdle: begin
            if (i_run_mode)  state_d = StRun;
            else if (i_step) state_d = StStep;
         end
         StRun: begin
            if (halt_go)          state_d = StDrain;
            else if (!i_run_mode) state_d = StIdle;
         end
         StStep: begin
            if (halt_go) state_d = StDrain;
            else         state_d = StIdle;
         end
         StDrain: begin
            if (drain_cnt_q == DRAIN_LAST) state_d = StHalted;
            else                           drain_cnt_d = drain_cnt_q + 1'b1;
         end
         StHalted: state_d = StHalted;
         default:  state_d = StIdle;
      endcase
   end

   // Output logic; stall takes priority over halt and redirect
   always_comb begin
      o_pc_en        = 1'b0;
      o_if_id_en     = 1'b0;
      o_if_id_flush  = 1'b0;
      o_id_ex_bubble = 1'b0;
      o_pipe_en      = 1'b0;
      if (adv) begin
         o_pipe_en = 1'b1;
         if (hazard) begin
            o_id_ex_bubble = 1'b1;
         end else if (!halt_go) begin
            o_pc_en       = 1'b1;
            o_if_id_en    = 1'b1;
            o_if_id_flush = i_id_pc_modify;
         end
      end else if (state_q == StDrain) begin
         o_pipe_en      = 1'b1;
         o_id_ex_bubble = 1'b1;
      end
   end

   // Saturating performance counters
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cycle_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (o_pipe_en && (cycle_cnt_q != '1)) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
         if (adv && hazard && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

   assign o_halted    = halted_q;
   assign o_cycle_cnt = cycle_cnt_q;
   assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: table of RUN-state vectors plus hand-written
// reset, single-step, halt/drain, reset-during-drain and counter saturation sequences.
module tb_pipeline_hazard_ctrl;

   logic        clk;
   logic        rst_n;
   logic        run_mode, step, id_valid, id_halt, id_uses_rt, id_pc_modify, ex_mem_read;
   logic [4:0]  id_rs, id_rt, ex_rt;

   logic        pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_en, halted;
   logic [31:0] cycle_cnt, stall_cnt;
   logic        pc_en4, if_id_en4, if_id_flush4, id_ex_bubble4, pipe_en4, halted4;
   logic [3:0]  cycle_cnt4, stall_cnt4;
   logic [4:0]  outs;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_cyc = 0;
   int exp_stall = 0;

   assign outs = {pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_en};

   pipeline_hazard_ctrl #(.CNT_W(32), .DRAIN_CYC(4)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_run_mode(run_mode), .i_step(step),
      .i_id_valid(id_valid), .i_id_halt(id_halt), .i_id_rs(id_rs), .i_id_rt(id_rt),
      .i_id_uses_rt(id_uses_rt), .i_id_pc_modify(id_pc_modify),
      .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt),
      .o_pc_en(pc_en), .o_if_id_en(if_id_en), .o_if_id_flush(if_id_flush),
      .o_id_ex_bubble(id_ex_bubble), .o_pipe_en(pipe_en), .o_halted(halted),
      .o_cycle_cnt(cycle_cnt), .o_stall_cnt(stall_cnt)
   );

   pipeline_hazard_ctrl #(.CNT_W(4), .DRAIN_CYC(4)) u_dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_run_mode(run_mode), .i_step(step),
      .i_id_valid(id_valid), .i_id_halt(id_halt), .i_id_rs(id_rs), .i_id_rt(id_rt),
      .i_id_uses_rt(id_uses_rt), .i_id_pc_modify(id_pc_modify),
      .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt),
      .o_pc_en(pc_en4), .o_if_id_en(if_id_en4), .o_if_id_flush(if_id_flush4),
      .o_id_ex_bubble(id_ex_bubble4), .o_pipe_en(pipe_en4), .o_halted(halted4),
      .o_cycle_cnt(cycle_cnt4), .o_stall_cnt(stall_cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       valid, halt, uses_rt, pc_mod, mem_rd;
      logic [4:0] rs, rt, ert;
      logic [4:0] exp;   // {pc_en, if_id_en, flush, bubble, pipe_en}
      logic       hz;
   } vec_t;

   vec_t tbl[11];

   function automatic vec_t mk(input logic v, input logic h, input logic [4:0] rs,
                               input logic [4:0] rt, input logic u, input logic pm,
                               input logic mr, input logic [4:0] ert,
                               input logic [4:0] e, input logic hz);
      vec_t r;
      r.valid = v;  r.halt = h;   r.rs = rs;  r.rt = rt;   r.uses_rt = u;
      r.pc_mod = pm; r.mem_rd = mr; r.ert = ert; r.exp = e; r.hz = hz;
      return r;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic benign();
      id_valid = 1'b1; id_halt = 1'b0; id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b1;
      id_pc_modify = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0; step = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      check("reset outs", {27'd0, outs}, 32'd0);
      check("reset halted", {31'd0, halted}, 32'd0);
      check("reset cycle_cnt", cycle_cnt, 32'd0);
      check("reset stall_cnt", stall_cnt, 32'd0);
      check("reset cnt4", {28'd0, cycle_cnt4}, 32'd0);
      exp_cyc = 0;
      exp_stall = 0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //                 v  h  rs     rt     u  pm mr ert    exp       hz
      tbl[0]  = mk(1, 0, 5'd1, 5'd2, 1, 0, 0, 5'd0, 5'b11001, 0);
      tbl[1]  = mk(1, 0, 5'd5, 5'd2, 0, 0, 1, 5'd5, 5'b00011, 1);
      tbl[2]  = mk(1, 0, 5'd0, 5'd0, 1, 0, 1, 5'd0, 5'b11001, 0);
      tbl[3]  = mk(1, 0, 5'd3, 5'd7, 1, 0, 1, 5'd7, 5'b00011, 1);
      tbl[4]  = mk(1, 0, 5'd3, 5'd7, 0, 0, 1, 5'd7, 5'b11001, 0);
      tbl[5]  = mk(1, 0, 5'd5, 5'd2, 1, 0, 0, 5'd5, 5'b11001, 0);
      tbl[6]  = mk(1, 0, 5'd1, 5'd2, 1, 1, 0, 5'd0, 5'b11101, 0);
      tbl[7]  = mk(1, 0, 5'd9, 5'd2, 1, 1, 1, 5'd9, 5'b00011, 1);
      tbl[8]  = mk(0, 0, 5'd9, 5'd2, 1, 0, 1, 5'd9, 5'b11001, 0);
      tbl[9]  = mk(1, 1, 5'd4, 5'd2, 1, 0, 1, 5'd4, 5'b00011, 1);
      tbl[10] = mk(0, 1, 5'd1, 5'd2, 1, 0, 0, 5'd0, 5'b11001, 0);

      run_mode = 1'b0;
      benign();
      do_reset();

      // Continuous run, no hazards
      run_mode = 1'b1;
      #1;
      check("run idle first cycle", {27'd0, outs}, 32'd0);
      tick();
      check("run adv outs", {27'd0, outs}, {27'd0, 5'b11001});
      for (int k = 0; k < 9; k++) begin
         exp_cyc++;
         tick();
      end
      check("cycle_cnt after 10 cyc", cycle_cnt, 32'(exp_cyc));

      // Combinational decode in RUN
      for (int i = 0; i < 11; i++) begin
         id_valid = tbl[i].valid;  id_halt = tbl[i].halt;   id_rs = tbl[i].rs;
         id_rt = tbl[i].rt;        id_uses_rt = tbl[i].uses_rt;
         id_pc_modify = tbl[i].pc_mod; ex_mem_read = tbl[i].mem_rd; ex_rt = tbl[i].ert;
         #1;
         check($sformatf("vec %0d outs", i), {27'd0, outs}, {27'd0, tbl[i].exp});
         exp_cyc++;
         if (tbl[i].hz) exp_stall++;
         tick();
      end
      benign();
      #1;
      check("table cycle_cnt", cycle_cnt, 32'(exp_cyc));
      check("table stall_cnt", stall_cnt, 32'(exp_stall));

      // Leaving run mode: current cycle still advances
      run_mode = 1'b0;
      #1;
      check("mode change same cycle", {27'd0, outs}, {27'd0, 5'b11001});
      tick();
      check("mode change next cycle idle", {27'd0, outs}, 32'd0);

      // Single-step
      do_reset();
      run_mode = 1'b0;
      benign();
      #1;
      check("step idle frozen", {27'd0, outs}, 32'd0);
      for (int p = 0; p < 3; p++) begin
         step = 1'b1;
         #1;
         check($sformatf("step %0d request", p), {27'd0, outs}, 32'd0);
         tick();
         step = 1'b0;
         #1;
         check($sformatf("step %0d advance", p), {27'd0, outs}, {27'd0, 5'b11001});
         exp_cyc++;
         tick();
         check($sformatf("step %0d gap a", p), {27'd0, outs}, 32'd0);
         tick();
         check($sformatf("step %0d gap b", p), {27'd0, outs}, 32'd0);
         tick();
      end
      check("step cycle_cnt", cycle_cnt, 32'd3);

      // HALT and drain
      do_reset();
      benign();
      run_mode = 1'b1;
      tick();
      id_halt = 1'b1;
      #1;
      check("halt cycle outs", {27'd0, outs}, {27'd0, 5'b00001});
      exp_cyc++;
      tick();
      id_halt = 1'b0;
      run_mode = 1'b0;
      step = 1'b1;
      for (int d = 0; d < 4; d++) begin
         check($sformatf("drain %0d outs", d), {27'd0, outs}, {27'd0, 5'b00011});
         check($sformatf("drain %0d halted", d), {31'd0, halted}, 32'd0);
         exp_cyc++;
         tick();
      end
      check("halted flag", {31'd0, halted}, 32'd1);
      check("halted outs", {27'd0, outs}, 32'd0);
      run_mode = 1'b1;
      tick();
      tick();
      check("halted sticky", {31'd0, halted}, 32'd1);
      check("halted frozen outs", {27'd0, outs}, 32'd0);
      check("halt cycle_cnt", cycle_cnt, 32'(exp_cyc));

      // Reset in the middle of drain
      do_reset();
      benign();
      run_mode = 1'b1;
      tick();
      id_halt = 1'b1;
      tick();
      id_halt = 1'b0;
      tick();
      check("drain cycle 2 outs", {27'd0, outs}, {27'd0, 5'b00011});
      do_reset();
      run_mode = 1'b0;
      step = 1'b0;
      #1;
      check("post reset idle outs", {27'd0, outs}, 32'd0);
      check("post reset halted", {31'd0, halted}, 32'd0);

      // Counter saturation on the 4-bit instance
      run_mode = 1'b1;
      for (int k = 0; k < 20; k++) tick();
      check("cnt4 saturates", {28'd0, cycle_cnt4}, 32'd15);
      check("cnt32 after 20 cyc", cycle_cnt, 32'd19);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
